// File: rtl/mac_tile_lanes.sv
// Weight-stationary MAC tile with `lanes` activation slices, fused or split weights.
// Activations and instructions flow west->east, partial sums flow north->south.
module mac_tile_lanes #(
    parameter int bw      = 4,
    parameter int lanes   = 2,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic               mode_split,
    output logic               loaded
);
    localparam int SW = bw / lanes;
    localparam int PW = bw + SW + 1;
    localparam int CW = $clog2(lanes + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic                mode_reg;
    logic                loaded_reg;
    logic [bw-1:0]       a_reg;
    logic [psum_bw-1:0]  c_reg;
    logic [2:0]          inst_e_reg;
    logic [bw-1:0]       slot_reg [lanes];

    logic                load_accept;
    logic                split_now;
    logic [psum_bw-1:0]  term_split [lanes];
    logic [psum_bw-1:0]  term_fused [lanes];
    logic [psum_bw-1:0]  sum_next;

    assign load_accept = inst_w[0] && !inst_w[2] && (state_reg != FULL);
    // The mode is only sampled on the first beat; afterwards the latched copy rules.
    assign split_now   = (state_reg == EMPTY) ? mode_split : mode_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= EMPTY;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            loaded_reg <= 1'b0;
        end else if (inst_w[2]) begin
            state_reg  <= EMPTY;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            loaded_reg <= 1'b0;
        end else if (load_accept) begin
            case (state_reg)
                EMPTY: begin
                    mode_reg <= mode_split;
                    if (!mode_split || lanes == 1) begin
                        state_reg  <= FULL;
                        cnt_reg    <= CW'(lanes);
                        loaded_reg <= 1'b1;
                    end else begin
                        state_reg <= FILLING;
                        cnt_reg   <= CW'(1);
                    end
                end
                FILLING: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg + CW'(1) == CW'(lanes)) begin
                        state_reg  <= FULL;
                        loaded_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            c_reg      <= '0;
            inst_e_reg <= '0;
        end else begin
            if (inst_w[0] || inst_w[1]) begin
                a_reg <= in_w;
            end
            c_reg <= in_n;
            // Load beats are only passed on once this tile holds a full weight set.
            inst_e_reg <= {inst_w[2], inst_w[1],
                           inst_w[0] && !inst_w[2] && (state_reg == FULL)};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            logic [SW-1:0]        slice;
            logic signed [PW-1:0] prod;

            always_ff @(posedge clk) begin
                if (reset || inst_w[2]) begin
                    slot_reg[gi] <= '0;
                end else if (load_accept && (!split_now || cnt_reg == CW'(gi))) begin
                    slot_reg[gi] <= in_w;
                end
            end

            assign slice = a_reg[gi*SW +: SW];
            assign prod  = $signed(slot_reg[gi]) * $signed({1'b0, slice});
            assign term_split[gi] = {{(psum_bw-PW){prod[PW-1]}}, prod};
            assign term_fused[gi] = term_split[gi] << (gi * SW);
        end
    endgenerate

    always_comb begin
        sum_next = c_reg;
        for (int i = 0; i < lanes; i++) begin
            sum_next = sum_next + (mode_reg ? term_split[i] : term_fused[i]);
        end
    end

    assign out_s  = sum_next;
    assign out_e  = a_reg;
    assign inst_e = inst_e_reg;
    assign loaded = loaded_reg;
endmodule

// File: tb/tb_mac_tile_lanes.sv
// Directed bench for mac_tile_lanes (bw=4, lanes=2, psum_bw=16).
module tb_mac_tile_lanes;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_w;
    logic [3:0]  out_e;
    logic [15:0] in_n;
    logic [15:0] out_s;
    logic [2:0]  inst_w;
    logic [2:0]  inst_e;
    logic        mode_split;
    logic        loaded;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_tile_lanes #(.bw(4), .lanes(2), .psum_bw(16)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e),
        .in_n(in_n), .out_s(out_s), .inst_w(inst_w), .inst_e(inst_e),
        .mode_split(mode_split), .loaded(loaded)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] i, input logic [3:0] w,
                         input logic [15:0] n, input logic m);
        inst_w = i; in_w = w; in_n = n; mode_split = m;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            inst_w = 3'($urandom); in_w = 4'($urandom);
            in_n = 16'($urandom); mode_split = 1'($urandom);
            tick();
        end
        total++; if (out_s !== 16'd0) begin bad++; $display("FAIL reset_out_s got=%h want=0000", out_s); end
        total++; if (out_e !== 4'd0) begin bad++; $display("FAIL reset_out_e got=%h want=0", out_e); end
        total++; if (inst_e !== 3'b000) begin bad++; $display("FAIL reset_inst_e got=%b want=000", inst_e); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b want=0", loaded); end
        reset = 1'b0; inst_w = 3'b000; in_w = 4'h0; in_n = 16'd0; mode_split = 1'b0;
        $display("reset: out_s=%h out_e=%h inst_e=%b loaded=%b", out_s, out_e, inst_e, loaded);
    endtask

    task automatic test_fused();
        drive(3'b001, 4'hD, 16'd0, 1'b0);
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL fused_loaded got=%b want=1", loaded); end
        drive(3'b010, 4'hB, 16'd100, 1'b0);
        total++; if (out_s !== 16'd67) begin bad++; $display("FAIL fused_out_s got=%0d want=67", out_s); end
        total++; if (out_e !== 4'hB) begin bad++; $display("FAIL fused_out_e got=%h want=b", out_e); end
        total++; if (inst_e !== 3'b010) begin bad++; $display("FAIL fused_inst_e got=%b want=010", inst_e); end
        $display("fused: w=-3 a=11 n=100 out_s=%0d", out_s);
    endtask

    task automatic test_split();
        drive(3'b100, 4'h0, 16'd0, 1'b0);
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL split_clr_loaded got=%b want=0", loaded); end
        drive(3'b001, 4'h2, 16'd0, 1'b1);
        total++; if (inst_e[0] !== 1'b0) begin bad++; $display("FAIL split_fwd1 got=%b want=0", inst_e[0]); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL split_loaded1 got=%b want=0", loaded); end
        // mode input flips here; the latched split mode must persist
        drive(3'b001, 4'hF, 16'd0, 1'b0);
        total++; if (inst_e[0] !== 1'b0) begin bad++; $display("FAIL split_fwd2 got=%b want=0", inst_e[0]); end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL split_loaded2 got=%b want=1", loaded); end
        drive(3'b001, 4'h5, 16'd0, 1'b1);
        total++; if (inst_e[0] !== 1'b1) begin bad++; $display("FAIL split_fwd3 got=%b want=1", inst_e[0]); end
        drive(3'b010, 4'b0111, 16'd0, 1'b0);
        total++; if (out_s !== 16'd5) begin bad++; $display("FAIL split_out_s got=%0d want=5", out_s); end
        drive(3'b010, 4'b0001, 16'd0, 1'b0);
        total++; if (out_s !== 16'd2) begin bad++; $display("FAIL split_slot0 got=%h want=0002", out_s); end
        drive(3'b010, 4'b0100, 16'd0, 1'b0);
        total++; if (out_s !== 16'hFFFF) begin bad++; $display("FAIL split_slot1 got=%h want=ffff", out_s); end
        $display("split: slots 2,-1 a=0111 -> 5, last out_s=%h", out_s);
    endtask

    task automatic test_clear_collision();
        drive(3'b101, 4'h3, 16'd0, 1'b0);
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL clr_loaded got=%b want=0", loaded); end
        total++; if (inst_e !== 3'b100) begin bad++; $display("FAIL clr_inst_e got=%b want=100", inst_e); end
        drive(3'b010, 4'hF, 16'd7, 1'b0);
        total++; if (out_s !== 16'd7) begin bad++; $display("FAIL clr_out_s got=%0d want=7", out_s); end
        drive(3'b001, 4'h2, 16'd0, 1'b0);
        total++; if (inst_e[0] !== 1'b0) begin bad++; $display("FAIL clr_reload_fwd got=%b want=0", inst_e[0]); end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL clr_reload_loaded got=%b want=1", loaded); end
        $display("clear: inst_e=%b loaded=%b", inst_e, loaded);
    endtask

    task automatic test_wrap();
        drive(3'b100, 4'h0, 16'd0, 1'b0);
        drive(3'b001, 4'h1, 16'd0, 1'b0);
        drive(3'b010, 4'h1, 16'h7FFF, 1'b0);
        total++; if (out_s !== 16'h8000) begin bad++; $display("FAIL wrap_pos got=%h want=8000", out_s); end
        drive(3'b100, 4'h0, 16'd0, 1'b0);
        drive(3'b001, 4'h7, 16'd0, 1'b0);
        drive(3'b010, 4'hF, 16'hFFFF, 1'b0);
        total++; if (out_s !== 16'd104) begin bad++; $display("FAIL wrap_neg got=%0d want=104", out_s); end
        $display("wrap: out_s=%h", out_s);
    endtask

    task automatic test_reset_midload();
        drive(3'b100, 4'h0, 16'd0, 1'b0);
        drive(3'b001, 4'h3, 16'd0, 1'b1);
        reset = 1'b1;
        drive(3'b000, 4'h0, 16'd0, 1'b0);
        reset = 1'b0;
        drive(3'b001, 4'h1, 16'd0, 1'b1);
        drive(3'b001, 4'h1, 16'd0, 1'b1);
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL midload_loaded got=%b want=1", loaded); end
        drive(3'b010, 4'b0101, 16'd0, 1'b0);
        total++; if (out_s !== 16'd2) begin bad++; $display("FAIL midload_out_s got=%0d want=2", out_s); end
        $display("reset mid-load: out_s=%0d", out_s);
    endtask

    task automatic test_back_to_back();
        // slots are 1,1 in split mode from the previous test
        drive(3'b010, 4'h3, 16'd10, 1'b0);
        total++; if (out_s !== 16'd13) begin bad++; $display("FAIL b2b_0 got=%0d want=13", out_s); end
        drive(3'b010, 4'hF, 16'd20, 1'b0);
        total++; if (out_s !== 16'd26) begin bad++; $display("FAIL b2b_1 got=%0d want=26", out_s); end
        drive(3'b000, 4'h0, 16'd50, 1'b0);
        total++; if (out_s !== 16'd56) begin bad++; $display("FAIL b2b_hold got=%0d want=56", out_s); end
        total++; if (out_e !== 4'hF) begin bad++; $display("FAIL b2b_out_e got=%h want=f", out_e); end
        $display("back_to_back: out_s=%0d out_e=%h", out_s, out_e);
    endtask

    initial begin
        reset = 1'b1; inst_w = 3'b000; in_w = 4'h0; in_n = 16'd0; mode_split = 1'b0;
        test_reset();
        test_fused();
        test_split();
        test_clear_collision();
        test_wrap();
        test_reset_midload();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
